// File: rtl/maze_solver.sv
// maze_solver: left-hand wall follower over a privately latched 16x16 maze,
// emitting one visited cell per valid/ready beat. Define MAZE_SOLVER_STEP_LIMIT_EN to cap accepted steps at MAX_STEPS.
module maze_solver #(
  parameter int MAZE_W    = 16,
  parameter int MAZE_H    = 16,
  parameter int MAX_STEPS = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     maze_valid,
  input  logic [MAZE_W*MAZE_H-1:0] maze_data,
  input  logic [3:0]               start_x,
  input  logic [3:0]               start_y,
  input  logic [3:0]               goal_x,
  input  logic [3:0]               goal_y,
  output logic                     step_valid,
  input  logic                     step_ready,
  output logic [3:0]               step_x,
  output logic [3:0]               step_y,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic                     fail
);
  localparam int CELLS = MAZE_W * MAZE_H;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EMIT, S_DECIDE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   maze_q, maze_d;
  logic [3:0]         sx_q, sx_d, sy_q, sy_d, gx_q, gx_d, gy_q, gy_d;
  logic [3:0]         px_q, px_d, py_q, py_d;
  logic [1:0]         hd_q, hd_d;
  logic [9:0]         cnt_q, cnt_d, cnt_inc;
  logic               found_q, found_d, fail_q, fail_d;
  logic               hit, lim_hit;
  logic [1:0]         hk, hsel;
  logic [8:0]         pk, pick;

  // {open, nx, ny} for the neighbour in heading h; 5-bit math so any
  // step off the grid sets bit 4 and reads as a wall.
  function automatic logic [8:0] probe(input logic [CELLS-1:0] m, input logic [3:0] x,
                                       input logic [3:0] y, input logic [1:0] h);
    logic [4:0] nx, ny;
    nx = {1'b0, x};
    ny = {1'b0, y};
    case (h)
      2'd0:    ny = ny - 5'd1;
      2'd1:    nx = nx + 5'd1;
      2'd2:    ny = ny + 5'd1;
      default: nx = nx - 5'd1;
    endcase
    probe = {~(nx[4] | ny[4]) & m[{ny[3:0], nx[3:0]}], nx[3:0], ny[3:0]};
  endfunction

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    hsel = hd_q;
    hk   = '0;
    pk   = '0;
    // left, straight, right, back: first open neighbour wins
    for (int k = 0; k < 4; k++) begin
      hk = hd_q + 2'd3 + 2'(k);
      pk = probe(maze_q, px_q, py_q, hk);
      if (!hit && pk[8]) begin
        hit  = 1'b1;
        pick = pk;
        hsel = hk;
      end
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 10'd1;
`ifdef MAZE_SOLVER_STEP_LIMIT_EN
  assign lim_hit = int'(cnt_inc) >= MAX_STEPS;
`else
  assign lim_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    maze_d  = maze_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    px_d    = px_q;
    py_d    = py_q;
    hd_d    = hd_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: if (start && maze_valid) begin
        maze_d  = maze_data;
        sx_d    = start_x;
        sy_d    = start_y;
        gx_d    = goal_x;
        gy_d    = goal_y;
        cnt_d   = '0;
        found_d = 1'b0;
        fail_d  = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: if (!maze_q[{sy_q, sx_q}]) begin
        fail_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        px_d    = sx_q;
        py_d    = sy_q;
        hd_d    = 2'd1;
        state_d = S_EMIT;
      end
      S_EMIT: if (step_ready) begin
        cnt_d = cnt_inc;
        if (px_q == gx_q && py_q == gy_q) begin
          found_d = 1'b1;
          state_d = S_DONE;
        end else if (lim_hit) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: if (hit) begin
        px_d    = pick[7:4];
        py_d    = pick[3:0];
        hd_d    = hsel;
        state_d = S_EMIT;
      end else begin
        fail_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: if (!start) begin
        found_d = 1'b0;
        fail_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      maze_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      hd_q    <= 2'd1;
      cnt_q   <= '0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      maze_q  <= maze_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      hd_q    <= hd_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      fail_q  <= fail_d;
    end
  end

  assign step_valid = (state_q == S_EMIT);
  assign step_x     = px_q;
  assign step_y     = py_q;
  assign busy       = (state_q == S_CHECK) || (state_q == S_EMIT) || (state_q == S_DECIDE);
  assign done       = (state_q == S_DONE);
  assign found      = found_q;
  assign fail       = fail_q;
endmodule

// File: tb/tb_maze_solver.sv
// Bench for maze_solver: directed scenarios plus random mazes checked against
// a plain array-walking wall-follower model.
module tb_maze_solver;
  localparam int LIM = 8;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, maze_valid = 1'b0, step_ready = 1'b0;
  logic [255:0] maze_data = '0;
  logic [3:0]   start_x = '0, start_y = '0, goal_x = '0, goal_y = '0;
  logic         step_valid, busy, done, found, fail;
  logic [3:0]   step_x, step_y;

  int total = 0, bad = 0, cyc = 0;
  int obs_xy[$], obs_edge[$], exp_xy[$];
  bit exp_found, exp_fail, timeout, stall_ok;
  int acc_edge, done_edge;
  logic first_busy;

  maze_solver #(.MAZE_W(16), .MAZE_H(16), .MAX_STEPS(LIM)) dut (
    .clk(clk), .reset(reset), .start(start), .maze_valid(maze_valid), .maze_data(maze_data),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .step_valid(step_valid), .step_ready(step_ready), .step_x(step_x), .step_y(step_y),
    .busy(busy), .done(done), .found(found), .fail(fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // a handshake seen at this negedge completes on the coming posedge
  always @(negedge clk) if (step_valid && step_ready) begin
    obs_xy.push_back(int'({step_y, step_x}));
    obs_edge.push_back(cyc + 1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: walk the bitmap with the left-hand rule, cell index = x+16*y.
  task automatic model(input logic [255:0] m, input logic [3:0] sx, input logic [3:0] sy,
                       input logic [3:0] gx, input logic [3:0] gy, input int cap);
    int x, y, h, nx, ny, d;
    bit moved;
    int dx[4] = '{0, 1, 0, -1};
    int dy[4] = '{-1, 0, 1, 0};
    exp_xy.delete(); exp_found = 0; exp_fail = 0;
    x = int'(sx); y = int'(sy); h = 1;
    if (!m[x + 16 * y]) begin exp_fail = 1; return; end
    forever begin
      exp_xy.push_back(x + 16 * y);
      if (x == int'(gx) && y == int'(gy)) begin exp_found = 1; return; end
`ifdef MAZE_SOLVER_STEP_LIMIT_EN
      if (exp_xy.size() >= LIM) begin exp_fail = 1; return; end
`endif
      if (exp_xy.size() >= cap) return;
      moved = 0;
      for (int k = 0; k < 4 && !moved; k++) begin
        d = (h + 3 + k) % 4; nx = x + dx[d]; ny = y + dy[d];
        if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && m[nx + 16 * ny]) begin
          x = nx; y = ny; h = d; moved = 1;
        end
      end
      if (!moved) begin exp_fail = 1; return; end
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: stall third step 5 cycles and disturb inputs
  task automatic run_solve(input logic [255:0] m, input logic [3:0] sx, input logic [3:0] sy,
                           input logic [3:0] gx, input logic [3:0] gy, input int mode, input int max_obs);
    obs_xy.delete(); obs_edge.delete(); done_edge = -1; timeout = 1; stall_ok = 1;
    maze_data = m; start_x = sx; start_y = sy; goal_x = gx; goal_y = gy;
    maze_valid = 1; start = 1; step_ready = 1; acc_edge = cyc + 1;
    @(posedge clk); #1;
    first_busy = busy;
    for (int i = 0; i < 600; i++) begin
      if (done) begin done_edge = cyc + 1; timeout = 0; break; end
      if (obs_xy.size() >= max_obs) begin timeout = 0; break; end
      if (mode == 1) step_ready = 1'($urandom_range(1));
      else if (mode == 2 && step_valid && step_x == 4'd2 && obs_xy.size() == 2) begin
        step_ready = 0; maze_data = ~m; start_x = 4'd9;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          if (!(step_valid && step_x == 4'd2 && step_y == 4'd0)) stall_ok = 0;
        end
        step_ready = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    maze_data = '1; start = 1; maze_valid = 1; goal_x = 4'd5; goal_y = 4'd5;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if ({step_valid, step_x, step_y, busy, done, found, fail} !== 12'h0) begin
        bad++; $display("FAIL reset_outputs: got %h want 000", {step_valid, step_x, step_y, busy, done, found, fail});
      end
    end
    reset = 1; maze_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b0 || step_valid !== 1'b0 || obs_xy.size() != 0) begin
      bad++; $display("FAIL wait_maze_valid: busy=%b valid=%b steps=%0d want 0", busy, step_valid, obs_xy.size());
    end
    start = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_corridor();
    logic [255:0] m = '0;
    for (int i = 0; i < 6; i++) m[i] = 1'b1;
    run_solve(m, 4'd0, 4'd0, 4'd5, 4'd0, 2, 100);
    total++; if (timeout) begin bad++; $display("FAIL corr_timeout: got 1 want 0"); end
    total++; if (first_busy !== 1'b1) begin bad++; $display("FAIL corr_busy: got %b want 1", first_busy); end
    total++; if (obs_xy.size() != 6) begin bad++; $display("FAIL corr_count: got %0d want 6", obs_xy.size()); end
    for (int i = 0; i < 6 && i < obs_xy.size(); i++) begin
      total++; if (obs_xy[i] != i) begin bad++; $display("FAIL corr_step%0d: got %0d want %0d", i, obs_xy[i], i); end
    end
    total++; if (!stall_ok) begin bad++; $display("FAIL corr_backpressure: got unstable want (2,0) held"); end
    if (obs_xy.size() == 6) begin
      total++; if (obs_edge[0] != acc_edge + 2) begin bad++; $display("FAIL corr_first: got %0d want %0d", obs_edge[0], acc_edge + 2); end
      total++; if (obs_edge[1] - obs_edge[0] != 2) begin bad++; $display("FAIL corr_rate: got %0d want 2", obs_edge[1] - obs_edge[0]); end
      total++; if (obs_edge[2] - obs_edge[1] != 7) begin bad++; $display("FAIL corr_stall: got %0d want 7", obs_edge[2] - obs_edge[1]); end
      total++; if (obs_edge[3] - obs_edge[2] != 2) begin bad++; $display("FAIL corr_rate2: got %0d want 2", obs_edge[3] - obs_edge[2]); end
      total++; if (done_edge != obs_edge[5] + 1) begin bad++; $display("FAIL corr_done_edge: got %0d want %0d", done_edge, obs_edge[5] + 1); end
    end
    total++;
    if ({done, found, fail, step_valid} !== 4'b1100) begin
      bad++; $display("FAIL corr_status: got %b want 1100", {done, found, fail, step_valid});
    end
    start = 0; @(posedge clk); #1;
    total++; if ({done, found, fail} !== 3'b000) begin bad++; $display("FAIL corr_release: got %b want 000", {done, found, fail}); end
  endtask

  task automatic test_wall_start();
    logic [255:0] m = '0;
    run_solve(m, 4'd3, 4'd3, 4'd0, 4'd0, 0, 10);
    total++; if (obs_xy.size() != 0) begin bad++; $display("FAIL wall_steps: got %0d want 0", obs_xy.size()); end
    total++; if (done_edge != acc_edge + 2) begin bad++; $display("FAIL wall_done_edge: got %0d want %0d", done_edge, acc_edge + 2); end
    total++; if ({found, fail} !== 2'b01) begin bad++; $display("FAIL wall_flags: got %b want 01", {found, fail}); end
    start = 0; @(posedge clk); #1;
    m[3 + 16 * 3] = 1'b1;
    run_solve(m, 4'd3, 4'd3, 4'd0, 4'd0, 0, 10);
    total++;
    if (obs_xy.size() != 1 || {done, found, fail} !== 3'b101) begin
      bad++; $display("FAIL isolated: got steps=%0d flags=%b want 1 101", obs_xy.size(), {done, found, fail});
    end
    start = 0; @(posedge clk); #1;
  endtask

  task automatic test_dead_end();
    logic [255:0] m = '0;
    int want[6] = '{16, 17, 1, 17, 18, 19};
    m[16] = 1'b1; m[17] = 1'b1; m[18] = 1'b1; m[19] = 1'b1; m[1] = 1'b1;
    run_solve(m, 4'd0, 4'd1, 4'd3, 4'd1, 0, 50);
    total++; if (obs_xy.size() != 6) begin bad++; $display("FAIL dead_count: got %0d want 6", obs_xy.size()); end
    for (int i = 0; i < 6 && i < obs_xy.size(); i++) begin
      total++; if (obs_xy[i] != want[i]) begin bad++; $display("FAIL dead_step%0d: got %0d want %0d", i, obs_xy[i], want[i]); end
    end
    total++; if ({done, found, fail} !== 3'b110) begin bad++; $display("FAIL dead_flags: got %b want 110", {done, found, fail}); end
    start = 0; @(posedge clk); #1;
  endtask

  task automatic test_step_limit();
    logic [255:0] m = '0;
    m[0] = 1'b1; m[1] = 1'b1;
`ifdef MAZE_SOLVER_STEP_LIMIT_EN
    run_solve(m, 4'd0, 4'd0, 4'd5, 4'd5, 0, 100);
    total++; if (obs_xy.size() != LIM) begin bad++; $display("FAIL limit_count: got %0d want %0d", obs_xy.size(), LIM); end
    total++; if ({done, found, fail} !== 3'b101) begin bad++; $display("FAIL limit_flags: got %b want 101", {done, found, fail}); end
`else
    run_solve(m, 4'd0, 4'd0, 4'd5, 4'd5, 0, 12);
    total++; if (obs_xy.size() < 12) begin bad++; $display("FAIL nolimit_count: got %0d want >=12", obs_xy.size()); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL nolimit_done: got %b want 0", done); end
`endif
    for (int i = 0; i < obs_xy.size(); i++) begin
      total++; if (obs_xy[i] != i % 2) begin bad++; $display("FAIL limit_step%0d: got %0d want %0d", i, obs_xy[i], i % 2); end
    end
    step_ready = 0; start = 0; reset = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random_back_to_back();
    logic [255:0] m;
    logic [3:0] sx, sy, gx, gy;
    bit fin;
    for (int it = 0; it < 14; it++) begin
      for (int w = 0; w < 8; w++) m[w * 32 +: 32] = $urandom() | $urandom();
      sx = 4'($urandom_range(15)); sy = 4'($urandom_range(15));
      gx = 4'($urandom_range(15)); gy = 4'($urandom_range(15));
      if (it % 7 != 6) m[{sy, sx}] = 1'b1;
      if (it % 2 == 0) m[{gy, gx}] = 1'b1;
      model(m, sx, sy, gx, gy, 60);
      fin = exp_found || exp_fail;
      run_solve(m, sx, sy, gx, gy, 1, 60);
      total++; if (timeout) begin bad++; $display("FAIL rnd%0d_timeout: got 1 want 0", it); end
      total++;
      if (fin ? (obs_xy.size() != exp_xy.size()) : (obs_xy.size() < exp_xy.size())) begin
        bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, obs_xy.size(), exp_xy.size());
      end
      for (int i = 0; i < exp_xy.size() && i < obs_xy.size(); i++) begin
        total++;
        if (obs_xy[i] != exp_xy[i]) begin bad++; $display("FAIL rnd%0d_step%0d: got %0d want %0d", it, i, obs_xy[i], exp_xy[i]); end
      end
      if (fin) begin
        total++;
        if ({done, found, fail} !== {1'b1, exp_found, exp_fail}) begin
          bad++; $display("FAIL rnd%0d_flags: got %b want %b", it, {done, found, fail}, {1'b1, exp_found, exp_fail});
        end
        if (exp_found && obs_edge.size() > 0) begin
          total++;
          if (done_edge != obs_edge[obs_edge.size() - 1] + 1) begin
            bad++; $display("FAIL rnd%0d_done_edge: got %0d want %0d", it, done_edge, obs_edge[obs_edge.size() - 1] + 1);
          end
        end
        start = 0; @(posedge clk); #1;
        total++; if ({done, found, fail} !== 3'b000) begin bad++; $display("FAIL rnd%0d_release: got %b want 000", it, {done, found, fail}); end
      end else begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rnd%0d_running: got done=%b want 0", it, done); end
        step_ready = 0; start = 0; reset = 0;
        @(posedge clk); #1;
        total++;
        if ({step_valid, step_x, step_y, busy, done, found, fail} !== 12'h0) begin
          bad++; $display("FAIL rnd%0d_midreset: got %h want 000", it, {step_valid, step_x, step_y, busy, done, found, fail});
        end
        reset = 1;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_corridor();
    test_wall_start();
    test_dead_end();
    test_step_limit();
    test_random_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
